ap_total_stream_reader: RTL

- Read-side sequencer for the AP_total vector memory. The memory has a combinational read port.
- On a start command it walks a contiguous range of rows: it drives read_address, captures memory_output, and streams each row out over a valid/ready interface.
- Consumers are downstream dot-product and update units that take no_of_units elements per beat.
- It pairs with the existing write-side port, which is unchanged.

---
 rtl/ap_mem_pkg.sv | 17 +
 rtl/ap_total_stream_reader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ap_mem_pkg.sv
// rtl/ap_mem_pkg.sv - shared AP_total memory geometry and reader state encoding
package ap_mem_pkg;

  localparam int ELEMENT_WIDTH = 64;
  localparam int NO_OF_UNITS   = 8;
  localparam int ROW_WIDTH     = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int MEM_DEPTH     = 2001;
  localparam int ADDRESS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } reader_state_t;

endpackage

// File: rtl/ap_total_stream_reader.sv
// rtl/ap_total_stream_reader.sv - AP_total row streamer; optional AP_TOTAL_READER_BOUNDS_CHECK_EN range rejection
module ap_total_stream_reader
  import ap_mem_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int address_width = ADDRESS_WIDTH
`ifdef AP_TOTAL_READER_BOUNDS_CHECK_EN
  ,
  parameter int mem_depth     = MEM_DEPTH
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             length,
  output logic [address_width-1:0]             read_address,
  input  logic [element_width*no_of_units-1:0] memory_output,
  output logic [element_width*no_of_units-1:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error
);

  reader_state_t              state;
  reader_state_t              next_state;
  logic [address_width-1:0]   remaining;
  logic                       capture;
  logic                       reject;

  // A new row may be taken whenever the output register is empty or being drained this cycle.
  assign capture = (state == ST_STREAM) && (!out_valid || out_ready);

`ifdef AP_TOTAL_READER_BOUNDS_CHECK_EN
  logic [address_width:0] end_row;
  assign end_row = {1'b0, base_address} + {1'b0, length};
  assign reject  = end_row > (address_width + 1)'(mem_depth);
`else
  assign reject  = 1'b0;
`endif

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: rejected or empty commands go straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (reject || (length == '0)) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (capture && (remaining == address_width'(1))) begin
          next_state = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (out_valid && out_ready) begin
          next_state = ST_DONE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Address walk, row capture and output beat register; stalls leave everything untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_address <= '0;
      remaining    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !reject && (length != '0)) begin
            read_address <= base_address;
            remaining    <= length;
          end
        end
        ST_STREAM: begin
          if (capture) begin
            out_data     <= memory_output;
            out_valid    <= 1'b1;
            out_last     <= (remaining == address_width'(1));
            read_address <= read_address + address_width'(1);
            remaining    <= remaining - address_width'(1);
          end
        end
        ST_FLUSH: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef AP_TOTAL_READER_BOUNDS_CHECK_EN
  // Rejection flag is latched per accepted start and held until the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      error <= reject;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule
